axi_write_path_ctrl: RTL and testbench

- Sequencer for the single-master (M1) AXI write path of the interconnect.
- Decodes AWADDR_M1 and tracks the transaction through the AW, W and B phases, one outstanding write at a time.
- Drives registered 2-bit routing selects AW_state, W_state and B_state to the write address, write data and write response channel muxes.
- Includes a beat counter that checks WLAST against AWLEN.

---
 rtl/axi_route_pkg.sv | 24 ++
 rtl/axi_addr_decode.sv | 37 +++
 rtl/axi_write_path_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_axi_write_path_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_route_pkg.sv
// Shared routing definitions for the interconnect read/write path controllers:
// mux select encoding, slave base addresses and the decode-error response code.
package axi_route_pkg;

    typedef logic [1:0] route_sel_t;

    localparam route_sel_t IDLE   = 2'd0;
    localparam route_sel_t M1_S0  = 2'd1;
    localparam route_sel_t M1_S1  = 2'd2;
    localparam route_sel_t M1_DEF = 2'd3;

    localparam logic [31:0] S0_BASE_ADDR = 32'h0000_0000;
    localparam logic [31:0] S1_BASE_ADDR = 32'h0001_0000;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B
    } wr_state_t;

endpackage

// File: rtl/axi_addr_decode.sv
// Combinational address-to-route decoder. With AXI_DEFAULT_SLAVE_EN the full 64 KiB window
// is compared and unmapped addresses route to the default slave; otherwise bit 16 selects.
module axi_addr_decode
    import axi_route_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] S0_BASE = ADDR_W'(S0_BASE_ADDR),
    parameter logic [ADDR_W-1:0] S1_BASE = ADDR_W'(S1_BASE_ADDR)
) (
    input  logic [ADDR_W-1:0] i_addr,
    output route_sel_t        o_sel
);

    logic w_unused;

`ifdef AXI_DEFAULT_SLAVE_EN
    always_comb begin
        o_sel = M1_DEF;
        if (i_addr[ADDR_W-1:16] == S0_BASE[ADDR_W-1:16]) begin
            o_sel = M1_S0;
        end else if (i_addr[ADDR_W-1:16] == S1_BASE[ADDR_W-1:16]) begin
            o_sel = M1_S1;
        end
    end

    // Offset bits within the window never affect routing.
    assign w_unused = ^{i_addr[15:0], S0_BASE[15:0], S1_BASE[15:0]};
`else
    // Aliased decode: every address maps to one of the two slaves.
    always_comb begin
        o_sel = i_addr[16] ? M1_S1 : M1_S0;
    end

    assign w_unused = ^{i_addr[ADDR_W-1:17], i_addr[15:0], S0_BASE, S1_BASE};
`endif

endmodule

// File: rtl/axi_write_path_ctrl.sv
// Single-outstanding M1 write sequencer: AW -> W -> B with registered mux selects and a
// WLAST/AWLEN beat check. Define AXI_DEFAULT_SLAVE_EN to add the DECERR default slave.
module axi_write_path_ctrl
    import axi_route_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] S0_BASE = ADDR_W'(S0_BASE_ADDR),
    parameter logic [ADDR_W-1:0] S1_BASE = ADDR_W'(S1_BASE_ADDR)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ADDR_W-1:0] AWADDR_M1,
    input  logic [3:0]        AWLEN_M1,
    input  logic              AWVALID_M1,
    input  logic              AWREADY_S0,
    input  logic              AWREADY_S1,
    input  logic              WVALID_M1,
    input  logic              WLAST_M1,
    input  logic              WREADY_S0,
    input  logic              WREADY_S1,
    input  logic              BVALID_S0,
    input  logic              BVALID_S1,
    input  logic              BREADY_M1,
    output logic [1:0]        AW_state,
    output logic [1:0]        W_state,
    output logic [1:0]        B_state,
    output logic              busy,
`ifdef AXI_DEFAULT_SLAVE_EN
    output logic              AWREADY_DEF,
    output logic              WREADY_DEF,
    output logic              BVALID_DEF,
    output logic [1:0]        BRESP_DEF,
`endif
    output logic              wlast_err
);

    wr_state_t  r_state;
    route_sel_t r_tgt;
    logic [3:0] r_len_q;
    logic [3:0] r_beat_cnt;
    route_sel_t r_aw_state;
    route_sel_t r_w_state;
    route_sel_t r_b_state;
    logic       r_busy;
    logic       r_wlast_err;

    route_sel_t w_dec_sel;
    logic       w_awready_sel;
    logic       w_wready_sel;
    logic       w_bvalid_sel;
    logic       w_aw_hs;
    logic       w_w_hs;
    logic       w_b_hs;

    axi_addr_decode #(
        .ADDR_W  (ADDR_W),
        .S0_BASE (S0_BASE),
        .S1_BASE (S1_BASE)
    ) u_addr_decode (
        .i_addr (AWADDR_M1),
        .o_sel  (w_dec_sel)
    );

`ifdef AXI_DEFAULT_SLAVE_EN
    logic r_awready_def;
    logic r_wready_def;
    logic r_bvalid_def;

    assign AWREADY_DEF = r_awready_def;
    assign WREADY_DEF  = r_wready_def;
    assign BVALID_DEF  = r_bvalid_def;
    assign BRESP_DEF   = RESP_DECERR;
`endif

    // Only the slave named by the latched target can complete a handshake.
    always_comb begin
        w_awready_sel = 1'b0;
        w_wready_sel  = 1'b0;
        w_bvalid_sel  = 1'b0;
        case (r_tgt)
            M1_S0: begin
                w_awready_sel = AWREADY_S0;
                w_wready_sel  = WREADY_S0;
                w_bvalid_sel  = BVALID_S0;
            end
            M1_S1: begin
                w_awready_sel = AWREADY_S1;
                w_wready_sel  = WREADY_S1;
                w_bvalid_sel  = BVALID_S1;
            end
`ifdef AXI_DEFAULT_SLAVE_EN
            M1_DEF: begin
                w_awready_sel = r_awready_def;
                w_wready_sel  = r_wready_def;
                w_bvalid_sel  = r_bvalid_def;
            end
`endif
            default: ;
        endcase
    end

    assign w_aw_hs = (r_state == ST_AW) && AWVALID_M1 && w_awready_sel;
    assign w_w_hs  = (r_state == ST_W)  && WVALID_M1  && w_wready_sel;
    assign w_b_hs  = (r_state == ST_B)  && w_bvalid_sel && BREADY_M1;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= ST_IDLE;
            r_tgt       <= IDLE;
            r_len_q     <= 4'd0;
            r_beat_cnt  <= 4'd0;
            r_aw_state  <= IDLE;
            r_w_state   <= IDLE;
            r_b_state   <= IDLE;
            r_busy      <= 1'b0;
            r_wlast_err <= 1'b0;
`ifdef AXI_DEFAULT_SLAVE_EN
            r_awready_def <= 1'b0;
            r_wready_def  <= 1'b0;
            r_bvalid_def  <= 1'b0;
`endif
        end else begin
            r_wlast_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (AWVALID_M1) begin
                        r_state    <= ST_AW;
                        r_tgt      <= w_dec_sel;
                        r_len_q    <= AWLEN_M1;
                        r_beat_cnt <= 4'd0;
                        r_aw_state <= w_dec_sel;
                        r_busy     <= 1'b1;
`ifdef AXI_DEFAULT_SLAVE_EN
                        r_awready_def <= 1'b1;
`endif
                    end
                end
                ST_AW: begin
                    if (w_aw_hs) begin
                        r_state    <= ST_W;
                        r_aw_state <= IDLE;
                        r_w_state  <= r_tgt;
`ifdef AXI_DEFAULT_SLAVE_EN
                        r_awready_def <= 1'b0;
                        r_wready_def  <= 1'b1;
`endif
                    end
                end
                ST_W: begin
                    if (w_w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                        // Flag a last beat that is early/late, or a missing WLAST on the final beat.
                        r_wlast_err <= WLAST_M1 ^ (r_beat_cnt == r_len_q);
                        if (WLAST_M1) begin
                            r_state   <= ST_B;
                            r_w_state <= IDLE;
                            r_b_state <= r_tgt;
`ifdef AXI_DEFAULT_SLAVE_EN
                            r_wready_def <= 1'b0;
                            r_bvalid_def <= 1'b1;
`endif
                        end
                    end
                end
                ST_B: begin
                    if (w_b_hs) begin
                        r_state   <= ST_IDLE;
                        r_b_state <= IDLE;
                        r_busy    <= 1'b0;
`ifdef AXI_DEFAULT_SLAVE_EN
                        r_bvalid_def <= 1'b0;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign AW_state  = r_aw_state;
    assign W_state   = r_w_state;
    assign B_state   = r_b_state;
    assign busy      = r_busy;
    assign wlast_err = r_wlast_err;

endmodule

// File: tb/tb_axi_write_path_ctrl.sv
// Directed table-driven bench for axi_write_path_ctrl, plus hand sequences for async
// reset mid-burst and the 0x8000_0000 default-slave / aliasing case.
module tb_axi_write_path_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] AWADDR_M1;
    logic [3:0]  AWLEN_M1;
    logic        AWVALID_M1, AWREADY_S0, AWREADY_S1;
    logic        WVALID_M1, WLAST_M1, WREADY_S0, WREADY_S1;
    logic        BVALID_S0, BVALID_S1, BREADY_M1;
    logic [1:0]  AW_state, W_state, B_state;
    logic        busy, wlast_err;
`ifdef AXI_DEFAULT_SLAVE_EN
    logic        AWREADY_DEF, WREADY_DEF, BVALID_DEF;
    logic [1:0]  BRESP_DEF;
`endif

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    axi_write_path_ctrl dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .AWADDR_M1  (AWADDR_M1),
        .AWLEN_M1   (AWLEN_M1),
        .AWVALID_M1 (AWVALID_M1),
        .AWREADY_S0 (AWREADY_S0),
        .AWREADY_S1 (AWREADY_S1),
        .WVALID_M1  (WVALID_M1),
        .WLAST_M1   (WLAST_M1),
        .WREADY_S0  (WREADY_S0),
        .WREADY_S1  (WREADY_S1),
        .BVALID_S0  (BVALID_S0),
        .BVALID_S1  (BVALID_S1),
        .BREADY_M1  (BREADY_M1),
        .AW_state   (AW_state),
        .W_state    (W_state),
        .B_state    (B_state),
        .busy       (busy),
`ifdef AXI_DEFAULT_SLAVE_EN
        .AWREADY_DEF(AWREADY_DEF),
        .WREADY_DEF (WREADY_DEF),
        .BVALID_DEF (BVALID_DEF),
        .BRESP_DEF  (BRESP_DEF),
`endif
        .wlast_err  (wlast_err)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  len;
        logic        awv, awr0, awr1;
        logic        wv, wl, wr0, wr1;
        logic        bv0, bv1, br;
        logic [1:0]  aw, w, b;
        logic        bsy, err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string n, input logic [31:0] a, input logic [3:0] l,
                                input logic awv, input logic awr0, input logic awr1,
                                input logic wv, input logic wl, input logic wr0,
                                input logic wr1, input logic bv0, input logic bv1,
                                input logic br, input logic [1:0] aw, input logic [1:0] w,
                                input logic [1:0] b, input logic bsy, input logic err);
        vec_t v;
        v.name = n; v.addr = a; v.len = l;
        v.awv = awv; v.awr0 = awr0; v.awr1 = awr1;
        v.wv = wv; v.wl = wl; v.wr0 = wr0; v.wr1 = wr1;
        v.bv0 = bv0; v.bv1 = bv1; v.br = br;
        v.aw = aw; v.w = w; v.b = b; v.bsy = bsy; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [31:0] a, input logic [3:0] l, input logic awv,
                         input logic awr0, input logic awr1, input logic wv, input logic wl,
                         input logic wr0, input logic wr1, input logic bv0, input logic bv1,
                         input logic br);
        AWADDR_M1 = a; AWLEN_M1 = l; AWVALID_M1 = awv; AWREADY_S0 = awr0; AWREADY_S1 = awr1;
        WVALID_M1 = wv; WLAST_M1 = wl; WREADY_S0 = wr0; WREADY_S1 = wr1;
        BVALID_S0 = bv0; BVALID_S1 = bv1; BREADY_M1 = br;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_out(input string n, input logic [1:0] aw, input logic [1:0] w,
                             input logic [1:0] b, input logic bsy, input logic err);
        logic [7:0] got, exp;
        got = {AW_state, W_state, B_state, busy, wlast_err};
        exp = {aw, w, b, bsy, err};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got aw=%0d w=%0d b=%0d busy=%0d err=%0d, want aw=%0d w=%0d b=%0d busy=%0d err=%0d",
                     n, AW_state, W_state, B_state, busy, wlast_err, aw, w, b, bsy, err);
        end
    endtask

    task automatic check_val(input string n, input logic [1:0] got, input logic [1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", n, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // name, addr, len, awv awr0 awr1, wv wl wr0 wr1, bv0 bv1 br, exp aw w b busy err
        add("s1_aw",      32'h40,    0, 1,0,0, 0,0,0,0, 0,0,0, 1,0,0,1,0);
        add("s1_aw_wait", 32'h40,    0, 1,0,0, 0,0,0,0, 0,0,0, 1,0,0,1,0);
        add("s1_aw_hs",   32'h40,    0, 1,1,0, 0,0,0,0, 0,0,0, 0,1,0,1,0);
        add("s1_w",       32'h0,     0, 0,0,0, 1,1,1,0, 0,0,0, 0,0,1,1,0);
        add("s1_b",       32'h0,     0, 0,0,0, 0,0,0,0, 1,0,1, 0,0,0,0,0);
        add("s2_aw",      32'h10010, 3, 1,0,1, 0,0,0,0, 0,0,0, 2,0,0,1,0);
        add("s2_aw_mask", 32'h10010, 3, 1,1,0, 0,0,0,0, 0,0,0, 2,0,0,1,0);
        add("s2_aw_hs",   32'h10010, 3, 1,0,1, 0,0,0,0, 0,0,0, 0,2,0,1,0);
        add("s2_w0",      32'h0,     0, 0,0,0, 1,0,0,1, 0,0,0, 0,2,0,1,0);
        add("s2_w_mask",  32'h0,     0, 0,0,0, 1,0,1,0, 0,0,0, 0,2,0,1,0);
        add("s2_w1",      32'h0,     0, 0,0,0, 1,0,0,1, 0,0,0, 0,2,0,1,0);
        add("s2_w_stall", 32'h0,     0, 0,0,0, 1,0,0,0, 0,0,0, 0,2,0,1,0);
        add("s2_w2",      32'h0,     0, 0,0,0, 1,0,0,1, 0,0,0, 0,2,0,1,0);
        add("s2_wl_stall",32'h0,     0, 0,0,0, 1,1,0,0, 0,0,0, 0,2,0,1,0);
        add("s2_w3_last", 32'h0,     0, 0,0,0, 1,1,0,1, 0,0,0, 0,0,2,1,0);
        add("s2_b_mask",  32'h0,     0, 0,0,0, 0,0,0,0, 1,0,1, 0,0,2,1,0);
        add("s2_b_hold1", 32'h0,     0, 0,0,0, 0,0,0,0, 0,1,0, 0,0,2,1,0);
        add("s2_b_hold2", 32'h0,     0, 0,0,0, 0,0,0,0, 0,1,0, 0,0,2,1,0);
        add("s2_b_hold3", 32'h0,     0, 0,0,0, 0,0,0,0, 0,1,0, 0,0,2,1,0);
        add("s2_b_done",  32'h0,     0, 0,0,0, 0,0,0,0, 0,1,1, 0,0,0,0,0);
        add("s3_aw",      32'h100,   3, 1,0,0, 0,0,0,0, 0,0,0, 1,0,0,1,0);
        add("s3_aw_hs",   32'h100,   3, 1,1,0, 0,0,0,0, 0,0,0, 0,1,0,1,0);
        add("s3_w0",      32'h0,     0, 0,0,0, 1,0,1,0, 0,0,0, 0,1,0,1,0);
        add("s3_w1_early",32'h0,     0, 0,0,0, 1,1,1,0, 0,0,0, 0,0,1,1,1);
        add("s3_err_once",32'h0,     0, 0,0,0, 0,0,0,0, 0,0,0, 0,0,1,1,0);
        add("s3_b_done",  32'h0,     0, 0,0,0, 0,0,0,0, 1,0,1, 0,0,0,0,0);
        add("s4_aw_alias",32'h30000, 0, 1,0,0, 0,0,0,0, 0,0,0, 2,0,0,1,0);
        add("s4_aw_hs",   32'h30000, 0, 1,0,1, 0,0,0,0, 0,0,0, 0,2,0,1,0);
        add("s4_no_last", 32'h0,     0, 0,0,0, 1,0,0,1, 0,0,0, 0,2,0,1,1);
        add("s4_late",    32'h0,     0, 0,0,0, 1,1,0,1, 0,0,0, 0,0,2,1,1);
        add("s4_b_done",  32'h0,     0, 0,0,0, 0,0,0,0, 0,1,1, 0,0,0,0,0);
        add("s5_aw",      32'h80,    0, 1,0,0, 0,0,0,0, 0,0,0, 1,0,0,1,0);
        add("s5_aw_hs",   32'h80,    0, 1,1,0, 0,0,0,0, 0,0,0, 0,1,0,1,0);
        add("s5_w",       32'h0,     0, 0,0,0, 1,1,1,0, 0,0,0, 0,0,1,1,0);
        add("s5_b_mask",  32'h0,     0, 0,0,0, 0,0,0,0, 0,1,1, 0,0,1,1,0);
        add("s5_b_new_aw",32'h10000, 0, 1,0,0, 0,0,0,0, 1,0,1, 0,0,0,0,0);
        add("s5_aw2",     32'h10000, 0, 1,0,0, 0,0,0,0, 0,0,0, 2,0,0,1,0);
        add("s5_aw2_hs",  32'h10000, 0, 1,0,1, 0,0,0,0, 0,0,0, 0,2,0,1,0);
        add("s5_w2",      32'h0,     0, 0,0,0, 1,1,0,1, 0,0,0, 0,0,2,1,0);
        add("s5_b2_done", 32'h0,     0, 0,0,0, 0,0,0,0, 0,1,1, 0,0,0,0,0);

        ARESETn = 1'b0;
        drive(32'h0, 4'd0, 0,0,0, 0,0,0,0, 0,0,0);
        #12;
        check_out("reset_state", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        tick();
        ARESETn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].len, vecs[i].awv, vecs[i].awr0, vecs[i].awr1,
                  vecs[i].wv, vecs[i].wl, vecs[i].wr0, vecs[i].wr1,
                  vecs[i].bv0, vecs[i].bv1, vecs[i].br);
            tick();
            check_out(vecs[i].name, vecs[i].aw, vecs[i].w, vecs[i].b, vecs[i].bsy, vecs[i].err);
        end

        // Asynchronous reset in the middle of a burst.
        drive(32'h10000, 4'd3, 1,0,0, 0,0,0,0, 0,0,0);
        tick();
        drive(32'h10000, 4'd3, 1,0,1, 0,0,0,0, 0,0,0);
        tick();
        drive(32'h0, 4'd0, 0,0,0, 1,0,0,1, 0,0,0);
        tick();
        check_out("rst_pre", 2'd0, 2'd2, 2'd0, 1'b1, 1'b0);
        drive(32'h0, 4'd0, 0,0,0, 0,0,0,0, 0,0,0);
        #2;
        ARESETn = 1'b0;
        #1;
        check_out("rst_async", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        #2;
        ARESETn = 1'b1;
        drive(32'h40, 4'd0, 1,0,0, 0,0,0,0, 0,0,0);
        tick();
        check_out("rst_fresh_aw", 2'd1, 2'd0, 2'd0, 1'b1, 1'b0);
        drive(32'h40, 4'd0, 1,1,0, 0,0,0,0, 0,0,0);
        tick();
        drive(32'h0, 4'd0, 0,0,0, 1,1,1,0, 0,0,0);
        tick();
        check_out("rst_fresh_w", 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
        drive(32'h0, 4'd0, 0,0,0, 0,0,0,0, 1,0,1);
        tick();
        check_out("rst_fresh_b", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);

        // 0x8000_0000: default slave when enabled, aliases onto S0 otherwise.
`ifdef AXI_DEFAULT_SLAVE_EN
        drive(32'h8000_0000, 4'd0, 1,0,0, 0,0,0,0, 0,0,0);
        tick();
        check_out("def_aw", 2'd3, 2'd0, 2'd0, 1'b1, 1'b0);
        check_val("def_awready", {1'b0, AWREADY_DEF}, 2'd1);
        check_val("def_bresp", BRESP_DEF, 2'b11);
        tick();
        check_out("def_w_sel", 2'd0, 2'd3, 2'd0, 1'b1, 1'b0);
        drive(32'h0, 4'd0, 0,0,0, 1,1,0,0, 0,0,0);
        tick();
        check_out("def_b_sel", 2'd0, 2'd0, 2'd3, 1'b1, 1'b0);
        check_val("def_bvalid", {1'b0, BVALID_DEF}, 2'd1);
        drive(32'h0, 4'd0, 0,0,0, 0,0,0,0, 0,0,1);
        tick();
        check_out("def_done", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
`else
        drive(32'h8000_0000, 4'd0, 1,0,0, 0,0,0,0, 0,0,0);
        tick();
        check_out("hi_aw_s0", 2'd1, 2'd0, 2'd0, 1'b1, 1'b0);
        drive(32'h8000_0000, 4'd0, 1,1,0, 0,0,0,0, 0,0,0);
        tick();
        check_out("hi_w_s0", 2'd0, 2'd1, 2'd0, 1'b1, 1'b0);
        drive(32'h0, 4'd0, 0,0,0, 1,1,1,0, 0,0,0);
        tick();
        check_out("hi_b_s0", 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
        drive(32'h0, 4'd0, 0,0,0, 0,0,0,0, 1,0,1);
        tick();
        check_out("hi_done", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
